riscv_step_ctrl: RTL and testbench

//  Multi-cycle sequencer for the single-issue RISC-V core. Debounces the board step button,

---
 rtl/riscv_step_ctrl.sv | 100 ++++++++++
 tb/tb_riscv_step_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/riscv_step_ctrl.sv
// riscv_step_ctrl: debounced step button driving a multi-cycle FETCH/DECODE/READ/EXEC/WB sequencer
// Optional feature macro: RISCV_AUTORUN_EN (step button toggles a free-running mode)
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   btn                 raw asynchronous step button, active-high
//   mem_ready           instruction memory has fetched inst
//   result_ready        ALU result valid
//   mem_start           pulse: begin fetch at current pc
//   decode_start        pulse: latch/decode inst
//   read_en             pulse: register-file read of rs1/rs2
//   alu_start           pulse: launch ALU op
//   wb_en, pc_en        coincident pulses: write back rd, advance pc
//   busy                high in every state except IDLE and FAULT
//   fault               high while in FAULT
//   step_count          retired-instruction counter, wraps at 16 bits
module riscv_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn,
  input  logic        mem_ready,
  input  logic        result_ready,
  output logic        mem_start,
  output logic        decode_start,
  output logic        read_en,
  output logic        alu_start,
  output logic        wb_en,
  output logic        pc_en,
  output logic        busy,
  output logic        fault,
  output logic [15:0] step_count
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  // FETCH is split so mem_start is a clean entry-cycle pulse and mem_ready is only sampled afterwards
  typedef enum logic [3:0] {IDLE, FETCH, FETCH_WAIT, DECODE, READ, EXEC, WAIT_ALU, WB, FAULT} state_t;
  state_t state, state_nx;
  logic sync0, sync1, deb, step, run;
  logic [DW-1:0] deb_cnt;
  logic [7:0] wait_cnt;
  logic deb_hit, waiting, timeout;
  // the debounced level flips on the last of DEBOUNCE_CYCLES consecutive mismatching cycles
  assign deb_hit = (sync1 != deb) && (deb_cnt == DB_LAST);
  assign waiting = state == FETCH_WAIT || state == WAIT_ALU;
  assign timeout = wait_cnt == TO_LAST;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sync0      <= 1'b0;
      sync1      <= 1'b0;
      deb        <= 1'b0;
      deb_cnt    <= '0;
      step       <= 1'b0;
      state      <= IDLE;
      wait_cnt   <= 8'd0;
      step_count <= 16'd0;
    end else begin
      sync0      <= btn;
      sync1      <= sync0;
      deb_cnt    <= (sync1 != deb && !deb_hit) ? deb_cnt + 1'b1 : '0;
      deb        <= deb_hit ? sync1 : deb;
      step       <= deb_hit && sync1;
      state      <= state_nx;
      wait_cnt   <= waiting ? wait_cnt + 8'd1 : 8'd0;
      step_count <= step_count + {15'd0, state == WB};
    end
`ifdef RISCV_AUTORUN_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) run <= 1'b0;
    else run <= run ^ step;
`else
  assign run = 1'b0;
`endif
  // a ready on the timeout cycle is checked first, so it wins over the fault
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:       state_nx = step ? FETCH : IDLE;
      FETCH:      state_nx = FETCH_WAIT;
      FETCH_WAIT: state_nx = mem_ready ? DECODE : timeout ? FAULT : FETCH_WAIT;
      DECODE:     state_nx = READ;
      READ:       state_nx = EXEC;
      EXEC:       state_nx = WAIT_ALU;
      WAIT_ALU:   state_nx = result_ready ? WB : timeout ? FAULT : WAIT_ALU;
      WB:         state_nx = run ? FETCH : IDLE;
      FAULT:      state_nx = step ? IDLE : FAULT;
      default:    state_nx = IDLE;
    endcase
  end
  assign mem_start    = state == FETCH;
  assign decode_start = state == DECODE;
  assign read_en      = state == READ;
  assign alu_start    = state == EXEC;
  assign wb_en        = state == WB;
  assign pc_en        = state == WB;
  assign fault        = state == FAULT;
  assign busy         = state != IDLE && state != FAULT;
endmodule

// File: tb/tb_riscv_step_ctrl.sv
// tb_riscv_step_ctrl: self-checking bench for riscv_step_ctrl (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=8)
module tb_riscv_step_ctrl;
  localparam int DEB = 4;
  localparam int TO = 8;
  logic clk = 1'b0, rst = 1'b0, btn = 1'b0, mem_ready = 1'b0, result_ready = 1'b0;
  logic mem_start, decode_start, read_en, alu_start, wb_en, pc_en, busy, fault;
  logic [15:0] step_count;
  riscv_step_ctrl #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .btn(btn), .mem_ready(mem_ready), .result_ready(result_ready),
    .mem_start(mem_start), .decode_start(decode_start), .read_en(read_en), .alu_start(alu_start),
    .wb_en(wb_en), .pc_en(pc_en), .busy(busy), .fault(fault), .step_count(step_count)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {int c; logic [5:0] s;} ev_t;
  ev_t log_q[$];
  int fault_cyc = -1;
  logic fault_d = 1'b0;
  wire [5:0] strobes = {mem_start, decode_start, read_en, alu_start, wb_en, pc_en};
  always @(negedge clk) begin
    if (|strobes) log_q.push_back('{cyc, strobes});
    if (fault && !fault_d) fault_cyc = cyc;
    fault_d = fault;
  end
  int mem_lat = 1, alu_lat = 1, mt = 0, at = 0;
  bit marm = 0, aarm = 0;
  initial forever begin
    @(posedge clk);
    #2;
    if (!rst) begin marm = 0; aarm = 0; end
    if (mem_start) begin marm = 1; mt = mem_lat; end
    else if (marm) mt--;
    mem_ready = marm && mt == 0;
    if (mem_ready) marm = 0;
    if (alu_start) begin aarm = 1; at = alu_lat; end
    else if (aarm) at--;
    result_ready = aarm && at == 0;
    if (result_ready) aarm = 0;
  end
  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  int st, k0, foff;
  task automatic press(input int len, input int d, input int e);
    mem_lat = d;
    alu_lat = e;
    log_q.delete();
    fault_cyc = -1;
    st = cyc;
    btn = 1'b1;
    tick(len);
    btn = 1'b0;
    for (int i = 0; i < 80 && busy; i++) tick();
    tick(12);
    k0 = -1;
    foreach (log_q[j]) if (log_q[j].s[5] && k0 < 0) k0 = log_q[j].c;
    foff = (fault_cyc < 0) ? -1 : fault_cyc - k0;
  endtask
  typedef struct {int len, d, e, n_ev, wb_off, flt, f_off, inc;} vec_t;
  vec_t tbl[9];
  ev_t exp_q[$];
  logic [15:0] exp_cnt = 16'd0;
  bit mflt = 0;
  int wb, d, e, ef;
  initial begin
    tbl[0] = '{3, 1, 1, 0, -1, 0, -1, 0};
    tbl[1] = '{10, 1, 1, 5, 6, 0, -1, 1};
    tbl[2] = '{10, 1, 20, 4, -1, 1, 13, 0};
    tbl[3] = '{10, 1, 1, 0, -1, 0, -1, 0};
    tbl[4] = '{10, 8, 8, 5, 20, 0, -1, 1};
    tbl[5] = '{10, 9, 1, 1, -1, 1, 9, 0};
    tbl[6] = '{10, 1, 1, 0, -1, 0, -1, 0};
    tbl[7] = '{10, 1, 9, 4, -1, 1, 13, 0};
    tbl[8] = '{10, 1, 1, 0, -1, 0, -1, 0};
    tick(3);
    chk("reset_strobes", {26'd0, strobes}, 0);
    chk("reset_busy", busy, 0);
    chk("reset_fault", fault, 0);
    chk("reset_count", step_count, 0);
    rst = 1'b1;
    tick(3);
`ifdef RISCV_AUTORUN_EN
    mem_lat = 1;
    alu_lat = 1;
    log_q.delete();
    btn = 1'b1;
    tick(10);
    btn = 1'b0;
    tick(40);
    wb = 0;
    foreach (log_q[j]) if (log_q[j].s[1]) wb++;
    chk("autorun_multi", wb >= 3, 1);
    btn = 1'b1;
    tick(10);
    btn = 1'b0;
    for (int i = 0; i < 40 && busy; i++) tick();
    tick(12);
    chk("autorun_stop_busy", busy, 0);
    chk("autorun_stop_fault", fault, 0);
    wb = log_q.size();
    tick(20);
    chk("autorun_quiet", log_q.size(), wb);
    chk("autorun_last_wb", log_q[log_q.size()-1].s, 6'b000011);
`else
    for (int i = 0; i < 9; i++) begin
      press(tbl[i].len, tbl[i].d, tbl[i].e);
      chk($sformatf("vec%0d_events", i), log_q.size(), tbl[i].n_ev);
      wb = -1;
      foreach (log_q[j]) if (log_q[j].s[1:0] != 2'b00) begin
        wb = log_q[j].c - k0;
        chk($sformatf("vec%0d_wb_bits", i), log_q[j].s, 6'b000011);
      end
      chk($sformatf("vec%0d_wb_off", i), wb, tbl[i].wb_off);
      chk($sformatf("vec%0d_fault", i), fault, tbl[i].flt);
      chk($sformatf("vec%0d_fault_off", i), foff, tbl[i].f_off);
      exp_cnt += 16'(tbl[i].inc);
      chk($sformatf("vec%0d_count", i), step_count, exp_cnt);
      chk($sformatf("vec%0d_busy", i), busy, 0);
      if (k0 >= 0) chk($sformatf("vec%0d_latency", i), (k0 - st >= 6) && (k0 - st <= 8), 1);
    end
    force dut.step_count = 16'hFFFF;
    tick();
    release dut.step_count;
    tick();
    exp_cnt = 16'hFFFF;
    chk("wrap_preload", step_count, exp_cnt);
    press(10, 1, 1);
    exp_cnt = exp_cnt + 16'd1;
    chk("wrap_count", step_count, exp_cnt);
    for (int n = 0; n < 12; n++) begin
      d = $urandom_range(1, 10);
      e = $urandom_range(1, 10);
      press(10, d, e);
      exp_q.delete();
      ef = -1;
      if (mflt) mflt = 0;
      else begin
        exp_q.push_back('{k0, 6'b100000});
        if (d > TO) begin mflt = 1; ef = TO + 1; end
        else begin
          exp_q.push_back('{k0 + d + 1, 6'b010000});
          exp_q.push_back('{k0 + d + 2, 6'b001000});
          exp_q.push_back('{k0 + d + 3, 6'b000100});
          if (e > TO) begin mflt = 1; ef = d + 4 + TO; end
          else begin
            exp_q.push_back('{k0 + d + e + 4, 6'b000011});
            exp_cnt = exp_cnt + 16'd1;
          end
        end
      end
      chk($sformatf("rnd%0d_d%0d_e%0d_events", n, d, e), log_q.size(), exp_q.size());
      if (log_q.size() == exp_q.size())
        foreach (exp_q[j]) begin
          chk($sformatf("rnd%0d_ev%0d_cyc", n, j), log_q[j].c, exp_q[j].c);
          chk($sformatf("rnd%0d_ev%0d_bits", n, j), log_q[j].s, exp_q[j].s);
        end
      chk($sformatf("rnd%0d_fault", n), fault, mflt);
      chk($sformatf("rnd%0d_fault_off", n), foff, ef);
      chk($sformatf("rnd%0d_count", n), step_count, exp_cnt);
      chk($sformatf("rnd%0d_busy", n), busy, 0);
    end
    if (mflt) press(10, 1, 1);
    chk("pre_reset_fault", fault, 0);
    mem_lat = 1;
    alu_lat = 30;
    log_q.delete();
    btn = 1'b1;
    tick(5);
    btn = 1'b0;
    tick(4);
    btn = 1'b1;
    tick(8);
    chk("second_press_busy", busy, 1);
    chk("second_press_alu", alu_start | mem_start, 0);
    wb = 0;
    foreach (log_q[j]) if (log_q[j].s[5]) wb++;
    chk("second_press_dropped", wb, 1);
    rst = 1'b0;
    #1;
    chk("async_rst_strobes", {26'd0, strobes}, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_fault", fault, 0);
    chk("async_rst_count", step_count, 0);
    tick(2);
    btn = 1'b0;
    tick(2);
    rst = 1'b1;
    log_q.delete();
    tick(20);
    chk("post_rst_no_strobes", log_q.size(), 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_count", step_count, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
